ball_dir_ctrl: RTL and testbench

- Rally controller for the pong datapath. It is the counterpart of the ball position register.
- Consumes the ball position (x_pos, y_pos) and both paddle positions.
- Produces the direction bits (x_in/y_in side), the position-enable and endgame that drive the ball position register, plus scores.
- Owns bounce detection, point scoring, serve sequencing and game-over.

---
 rtl/ball_dir_ctrl_pkg.sv | 19 +
 rtl/ball_dir_ctrl_step_divider.sv | 40 ++++
 rtl/ball_dir_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ball_dir_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ball_dir_ctrl_pkg.sv
// Shared types and constants for the pong rally controller.
package ball_dir_ctrl_pkg;

  typedef enum logic [1:0] {SERVE, PLAY, POINT, GAMEOVER} state_e;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  localparam int CENTRE  = 2;
  localparam int SCORE_W = 4;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Scores stick at the top value instead of wrapping to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/ball_dir_ctrl_step_divider.sv
// Modulo-STEP_DIV counter; step_o is a registered one-clock pulse while the
// counter sits at its last value.
module ball_dir_ctrl_step_divider #(
  parameter int STEP_DIV = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic step_o
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST     = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(STEP_DIV - 2);

  if (STEP_DIV < 2) begin : g_div_check
    $error("STEP_DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;

  // The pulse is registered one count early so it coincides with cnt_q == LAST.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    step_d = (cnt_q == PRE_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/ball_dir_ctrl.sv
// Pong rally controller: bounce detection, scoring, serve sequencing and
// game-over, all advancing once per ball step.
module ball_dir_ctrl
  import ball_dir_ctrl_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int PADDLE_LEN   = 3,
  parameter int STEP_DIV     = 1024,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_STEPS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIT_OF_WIDTH-1:0] x_pos,
  input  logic [BIT_OF_WIDTH-1:0] y_pos,
  input  logic [BIT_OF_WIDTH-1:0] paddle_l,
  input  logic [BIT_OF_WIDTH-1:0] paddle_r,
  output logic                    x_dir,
  output logic                    y_dir,
  output logic                    en,
  output logic                    endgame,
  output logic [SCORE_W-1:0]      score_l,
  output logic [SCORE_W-1:0]      score_r,
  output logic                    step
);

  localparam int PW = BIT_OF_WIDTH + 1;
  localparam int HW = (SERVE_STEPS < 1) ? 1 : $clog2(SERVE_STEPS + 1);

  localparam logic [BIT_OF_WIDTH-1:0] POS_MIN  = '0;
  localparam logic [BIT_OF_WIDTH-1:0] POS_L    = BIT_OF_WIDTH'(1);
  localparam logic [BIT_OF_WIDTH-1:0] POS_R    = BIT_OF_WIDTH'(WIDTH - 2);
  localparam logic [BIT_OF_WIDTH-1:0] POS_MAX  = BIT_OF_WIDTH'(WIDTH - 1);
  localparam logic [PW-1:0]           SPAN     = PW'(PADDLE_LEN - 1);
  localparam logic [HW-1:0]           HOLD_INIT = HW'(SERVE_STEPS);
  localparam logic [SCORE_W-1:0]      WIN      = SCORE_W'(WIN_SCORE);

  if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_win_check
    $error("WIN_SCORE must lie in 1..15");
  end

  ball_dir_ctrl_step_divider #(
    .STEP_DIV (STEP_DIV)
  ) u_step_divider (
    .clk    (clk),
    .rst    (rst),
    .step_o (step)
  );

  state_e             state_q, state_d;
  logic               x_dir_q, x_dir_d;
  logic               y_dir_q, y_dir_d;
  logic               en_q, en_d;
  logic               endgame_q, endgame_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               scorer_r_q, scorer_r_d;

  // Paddle spans are compared one bit wider so a paddle near the bottom edge
  // does not wrap around to the top rows.
  logic [PW-1:0] y_ext, pl_top, pl_bot, pr_top, pr_bot;
  logic          hit_l, hit_r, miss_l, miss_r, wall_hi, wall_lo;

  assign y_ext  = {1'b0, y_pos};
  assign pl_top = {1'b0, paddle_l};
  assign pl_bot = pl_top + SPAN;
  assign pr_top = {1'b0, paddle_r};
  assign pr_bot = pr_top + SPAN;

  assign hit_l   = (x_pos == POS_L) && (x_dir_q == DIR_DEC) && (y_ext >= pl_top) && (y_ext <= pl_bot);
  assign hit_r   = (x_pos == POS_R) && (x_dir_q == DIR_INC) && (y_ext >= pr_top) && (y_ext <= pr_bot);
  assign miss_l  = (x_pos == POS_MIN);
  assign miss_r  = (x_pos == POS_MAX);
  assign wall_hi = (y_pos == POS_MAX) && (y_dir_q == DIR_INC);
  assign wall_lo = (y_pos == POS_MIN) && (y_dir_q == DIR_DEC);

  always_comb begin
    state_d    = state_q;
    x_dir_d    = x_dir_q;
    y_dir_d    = y_dir_q;
    en_d       = en_q;
    endgame_d  = endgame_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    hold_d     = hold_q;
    scorer_r_d = scorer_r_q;

    if (step) begin
      case (state_q)
        SERVE: begin
          if (hold_q == '0) begin
            en_d    = 1'b1;
            state_d = PLAY;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        PLAY: begin
          // A miss ends the rally before any bounce is considered.
          if (miss_l) begin
            score_r_d  = sat_inc(score_r_q);
            scorer_r_d = 1'b1;
            state_d    = POINT;
          end else if (miss_r) begin
            score_l_d  = sat_inc(score_l_q);
            scorer_r_d = 1'b0;
            state_d    = POINT;
          end else begin
            if (wall_hi)      y_dir_d = DIR_DEC;
            else if (wall_lo) y_dir_d = DIR_INC;
            if (hit_l)        x_dir_d = DIR_INC;
            else if (hit_r)   x_dir_d = DIR_DEC;
          end
        end
        POINT: begin
          en_d    = 1'b0;
          hold_d  = HOLD_INIT;
          x_dir_d = scorer_r_q ? DIR_DEC : DIR_INC;
          y_dir_d = DIR_INC;
          if ((scorer_r_q ? score_r_q : score_l_q) == WIN) begin
            endgame_d = 1'b1;
            state_d   = GAMEOVER;
          end else begin
            state_d = SERVE;
          end
        end
        GAMEOVER: begin
          endgame_d = 1'b1;
          en_d      = 1'b0;
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SERVE;
      x_dir_q    <= DIR_INC;
      y_dir_q    <= DIR_INC;
      en_q       <= 1'b0;
      endgame_q  <= 1'b0;
      score_l_q  <= '0;
      score_r_q  <= '0;
      hold_q     <= HOLD_INIT;
      scorer_r_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_dir_q    <= x_dir_d;
      y_dir_q    <= y_dir_d;
      en_q       <= en_d;
      endgame_q  <= endgame_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      hold_q     <= hold_d;
      scorer_r_q <= scorer_r_d;
    end
  end

  assign x_dir   = x_dir_q;
  assign y_dir   = y_dir_q;
  assign en      = en_q;
  assign endgame = endgame_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// Directed bench for ball_dir_ctrl: expected outputs are queued per step and
// compared once the step's update edge has passed.
module tb_ball_dir_ctrl;
  import ball_dir_ctrl_pkg::*;

  localparam int STEP_DIV = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] x_pos, y_pos, paddle_l, paddle_r;
  logic       x_dir, y_dir, en, endgame, step;
  logic [3:0] score_l, score_r;

  always #5 clk = ~clk;

  ball_dir_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .paddle_l (paddle_l),
    .paddle_r (paddle_r),
    .x_dir    (x_dir),
    .y_dir    (y_dir),
    .en       (en),
    .endgame  (endgame),
    .score_l  (score_l),
    .score_r  (score_r),
    .step     (step)
  );

  typedef struct {
    string      tag;
    logic       xd;
    logic       yd;
    logic       en;
    logic       eg;
    logic [3:0] sl;
    logic [3:0] sr;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_step_cyc = -1;

  // Bench model of the rally state
  logic       m_xd, m_yd;
  logic [3:0] m_sl, m_sr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_pos(input int x, input int y, input int pl, input int pr);
    x_pos    = 3'(x);
    y_pos    = 3'(y);
    paddle_l = 3'(pl);
    paddle_r = 3'(pr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".x_dir"},   {7'd0, x_dir},   8'd0);
    check({tag, ".y_dir"},   {7'd0, y_dir},   8'd0);
    check({tag, ".en"},      {7'd0, en},      8'd0);
    check({tag, ".endgame"}, {7'd0, endgame}, 8'd0);
    check({tag, ".score_l"}, {4'd0, score_l}, 8'd0);
    check({tag, ".score_r"}, {4'd0, score_r}, 8'd0);
    check({tag, ".step"},    {7'd0, step},    8'd0);
  endtask

  // Queue the expectation, wait (bounded) for the step pulse, let the update
  // edge pass, then compare on the following falling edge.
  task automatic expect_step(input string tag, input logic xd, input logic yd,
                             input logic e, input logic eg,
                             input logic [3:0] sl, input logic [3:0] sr);
    exp_t want;
    exp_t got;
    int   n;
    want.tag = tag; want.xd = xd; want.yd = yd; want.en = e; want.eg = eg;
    want.sl = sl; want.sr = sr;
    sb.push_back(want);
    n = 0;
    while (step !== 1'b1 && n < 2 * STEP_DIV) begin
      @(negedge clk);
      n++;
    end
    got = sb.pop_front();
    if (step !== 1'b1) begin
      check({got.tag, ".step_timeout"}, {7'd0, step}, 8'd1);
    end else begin
      if (last_step_cyc >= 0)
        check({got.tag, ".step_period"}, 8'(cyc - last_step_cyc), 8'(STEP_DIV));
      last_step_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
      check({got.tag, ".x_dir"},   {7'd0, x_dir},   {7'd0, got.xd});
      check({got.tag, ".y_dir"},   {7'd0, y_dir},   {7'd0, got.yd});
      check({got.tag, ".en"},      {7'd0, en},      {7'd0, got.en});
      check({got.tag, ".endgame"}, {7'd0, endgame}, {7'd0, got.eg});
      check({got.tag, ".score_l"}, {4'd0, score_l}, {4'd0, got.sl});
      check({got.tag, ".score_r"}, {4'd0, score_r}, {4'd0, got.sr});
      $display("step %s xd=%b yd=%b en=%b eg=%b sl=%0d sr=%0d", got.tag,
               x_dir, y_dir, en, endgame, score_l, score_r);
    end
  endtask

  task automatic serve();
    expect_step("serve1", m_xd, m_yd, 1'b0, 1'b0, m_sl, m_sr);
    expect_step("serve2", m_xd, m_yd, 1'b0, 1'b0, m_sl, m_sr);
    expect_step("serve3", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);
  endtask

  // Ball escapes past the right paddle: left player scores.
  task automatic right_point();
    set_pos(7, 3, 0, 0);
    m_sl = (m_sl == 4'd15) ? 4'd15 : m_sl + 4'd1;
    expect_step("miss_r", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);
    m_xd = DIR_INC;
    m_yd = DIR_INC;
    if (m_sl == 4'd5) begin
      expect_step("point_win", m_xd, m_yd, 1'b0, 1'b1, m_sl, m_sr);
    end else begin
      expect_step("point_r", m_xd, m_yd, 1'b0, 1'b0, m_sl, m_sr);
      serve();
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs(tag);
    rst = 1'b0;
    last_step_cyc = -1;
    m_xd = 1'b0; m_yd = 1'b0; m_sl = 4'd0; m_sr = 4'd0;
  endtask

  initial begin
    set_pos(CENTRE, CENTRE, 0, 0);
    m_xd = 1'b0; m_yd = 1'b0; m_sl = 4'd0; m_sr = 4'd0;
    repeat (3) @(negedge clk);
    do_reset("reset");

    // Serve hold, then release
    serve();

    // Top wall
    set_pos(4, 7, 0, 0);
    m_yd = DIR_DEC;
    expect_step("ywall_hi", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);

    // Paddle hits, paddle gap, then left miss
    set_pos(6, 3, 0, 2);
    m_xd = DIR_DEC;
    expect_step("rpad_hit", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);
    set_pos(1, 3, 2, 2);
    m_xd = DIR_INC;
    expect_step("lpad_hit", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);
    set_pos(6, 3, 2, 2);
    m_xd = DIR_DEC;
    expect_step("rpad_hit2", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);
    set_pos(1, 3, 5, 2);
    expect_step("lpad_gap", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);
    set_pos(0, 3, 5, 2);
    m_sr = 4'd1;
    expect_step("miss_l", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);
    m_xd = DIR_DEC;
    m_yd = DIR_INC;
    expect_step("point_l", m_xd, m_yd, 1'b0, 1'b0, m_sl, m_sr);
    serve();

    // Set up x_dir=0, y_dir=1, then a corner bounce flips both
    set_pos(4, 7, 0, 0);
    m_yd = DIR_DEC;
    expect_step("ywall_hi2", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);
    set_pos(1, 3, 2, 0);
    m_xd = DIR_INC;
    expect_step("lpad_hit2", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);
    set_pos(6, 0, 2, 0);
    m_xd = DIR_DEC;
    m_yd = DIR_INC;
    expect_step("corner", m_xd, m_yd, 1'b1, 1'b0, m_sl, m_sr);

    // Left player runs to the winning score
    for (int i = 0; i < 5; i++) right_point();
    set_pos(7, 3, 0, 0);
    expect_step("gameover_r", m_xd, m_yd, 1'b0, 1'b1, m_sl, m_sr);
    set_pos(0, 3, 0, 0);
    expect_step("gameover_l", m_xd, m_yd, 1'b0, 1'b1, m_sl, m_sr);

    // Reset out of game-over, rebuild score_l=3, then reset mid-rally
    do_reset("reset_gameover");
    serve();
    for (int i = 0; i < 3; i++) right_point();
    set_pos(4, 3, 0, 0);
    repeat (STEP_DIV / 2) @(negedge clk);
    check("midrally.score_l_before", {4'd0, score_l}, 8'd3);
    do_reset("reset_midrally");
    set_pos(7, 3, 0, 0);
    serve();
    check("scoreboard_empty", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
